// File: rtl/g_reg_sb_file_if.sv
// Decode/writeback bus of the tagged register file: operand reads, reservation
// request/grant and the writeback return path.
interface g_reg_sb_file_if #(
  parameter int W_OPR = 32,
  parameter int W_RD  = 4,
  parameter int W_TAG = 3
);
  logic [W_RD-1:0]  r0_i;
  logic [W_RD-1:0]  r1_i;
  logic             r0_use_i;
  logic             r1_use_i;
  logic [W_RD-1:0]  rd_i;
  logic             w_reserve_i;
  logic [W_OPR-1:0] r_opr0_o;
  logic [W_OPR-1:0] r_opr1_o;
  logic             reserved_o;
  logic [W_TAG-1:0] rsv_tag_o;
  logic             rsv_ack_o;
  logic             wb_i;
  logic [W_RD-1:0]  wb_r_i;
  logic [W_TAG-1:0] wb_tag_i;
  logic [W_OPR-1:0] result_i;

  modport master (
    output r0_i, r1_i, r0_use_i, r1_use_i, rd_i, w_reserve_i,
    output wb_i, wb_r_i, wb_tag_i, result_i,
    input  r_opr0_o, r_opr1_o, reserved_o, rsv_tag_o, rsv_ack_o
  );

  modport slave (
    input  r0_i, r1_i, r0_use_i, r1_use_i, rd_i, w_reserve_i,
    input  wb_i, wb_r_i, wb_tag_i, result_i,
    output r_opr0_o, r_opr1_o, reserved_o, rsv_tag_o, rsv_ack_o
  );
endinterface

// File: rtl/g_reg_sb_file.sv
// General register file with a tagged scoreboard: per-register reservation tags
// make stale writebacks harmless, and a matching writeback bypasses to the reads.
module g_reg_sb_file #(
  parameter int W_OPR    = 32,
  parameter int N_REG    = 16,
  parameter int W_RD     = 4,
  parameter int W_TAG    = 3,
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            reset,
  g_reg_sb_file_if.slave  bus
);

  logic [W_OPR-1:0] data [N_REG];
  logic [W_TAG-1:0] tag  [N_REG];
  logic [N_REG-1:0] busy;
  logic [W_TAG-1:0] tcnt;

  logic [N_REG-1:0] hit;
  logic [W_OPR-1:0] opr0;
  logic [W_OPR-1:0] opr1;
  logic             pend0;
  logic             pend1;
  logic             reserved;
  logic             ack;
  logic             rsv_en;
  logic             wb_en;
  logic             zero0;
  logic             zero1;
  logic             zero_rd;

  // A writeback only counts when it carries the tag of the live reservation.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_REG; i++) begin
      hit[i] = bus.wb_i && (bus.wb_r_i == W_RD'(i)) && busy[i] &&
               (bus.wb_tag_i == tag[i]) && !((ZERO_REG != 0) && (i == 0));
    end
  end

  assign zero0   = (ZERO_REG != 0) && (bus.r0_i == '0);
  assign zero1   = (ZERO_REG != 0) && (bus.r1_i == '0);
  assign zero_rd = (ZERO_REG != 0) && (bus.rd_i == '0);

  always_comb begin
    opr0 = data[bus.r0_i];
    if (hit[bus.r0_i]) opr0 = bus.result_i;
    if (zero0)         opr0 = '0;
    opr1 = data[bus.r1_i];
    if (hit[bus.r1_i]) opr1 = bus.result_i;
    if (zero1)         opr1 = '0;
  end

  assign pend0    = bus.r0_use_i && busy[bus.r0_i] && !hit[bus.r0_i];
  assign pend1    = bus.r1_use_i && busy[bus.r1_i] && !hit[bus.r1_i];
  assign reserved = pend0 || pend1;
  assign ack      = bus.w_reserve_i && !reserved;
  assign rsv_en   = ack && !zero_rd;
  assign wb_en    = hit[bus.wb_r_i];

  assign bus.r_opr0_o   = opr0;
  assign bus.r_opr1_o   = opr1;
  assign bus.reserved_o = reserved;
  assign bus.rsv_ack_o  = ack;
  assign bus.rsv_tag_o  = tcnt;

  // Reservation is written after writeback so it owns busy/tag on a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REG; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
      busy <= '0;
      tcnt <= '0;
    end else begin
      if (wb_en) begin
        data[bus.wb_r_i] <= bus.result_i;
        busy[bus.wb_r_i] <= 1'b0;
      end
      if (rsv_en) begin
        busy[bus.rd_i] <= 1'b1;
        tag[bus.rd_i]  <= tcnt;
        tcnt           <= tcnt + W_TAG'(1);
      end
    end
  end

endmodule

// File: tb/tb_g_reg_sb_file.sv
// Bench for g_reg_sb_file: directed vector table, randomized run against a
// scoreboard model, and hand sequences for the zero register and async reset.
module tb_g_reg_sb_file;
  localparam int W_OPR = 32;
  localparam int N_REG = 16;
  localparam int W_RD  = 4;
  localparam int W_TAG = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  g_reg_sb_file_if #(.W_OPR(W_OPR), .W_RD(W_RD), .W_TAG(W_TAG)) bus0 ();
  g_reg_sb_file_if #(.W_OPR(W_OPR), .W_RD(W_RD), .W_TAG(W_TAG)) bus1 ();

  g_reg_sb_file #(.W_OPR(W_OPR), .N_REG(N_REG), .W_RD(W_RD), .W_TAG(W_TAG), .ZERO_REG(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  g_reg_sb_file #(.W_OPR(W_OPR), .N_REG(N_REG), .W_RD(W_RD), .W_TAG(W_TAG), .ZERO_REG(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [W_RD-1:0]  r0, r1;
    logic             u0, u1;
    logic [W_RD-1:0]  rd;
    logic             wres, wb;
    logic [W_RD-1:0]  wbr;
    logic [W_TAG-1:0] wbtag;
    logic [W_OPR-1:0] res;
  } in_t;

  typedef struct {
    logic [W_OPR-1:0] opr0, opr1;
    logic             rsvd, ack;
    logic [W_TAG-1:0] tag;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  int total = 0;
  int passed = 0;

  // Scoreboard model: instance 0 plain, instance 1 with hardwired zero register.
  logic [W_OPR-1:0] m_data [2][N_REG];
  logic             m_busy [2][N_REG];
  logic [W_TAG-1:0] m_tag  [2][N_REG];
  int               m_tcnt [2];

  function automatic in_t idle_in();
    in_t x;
    x.r0 = '0; x.r1 = '0; x.u0 = 1'b0; x.u1 = 1'b0; x.rd = '0; x.wres = 1'b0;
    x.wb = 1'b0; x.wbr = '0; x.wbtag = '0; x.res = '0;
    return x;
  endfunction

  function automatic vec_t mk(int r0, int u0, int r1, int u1, int wres, int rd,
                              int wb, int wbr, int wbtag, int res,
                              int e0, int e1, int ersv, int eack, int etag);
    vec_t v;
    v.i.r0 = W_RD'(r0); v.i.u0 = 1'(u0); v.i.r1 = W_RD'(r1); v.i.u1 = 1'(u1);
    v.i.wres = 1'(wres); v.i.rd = W_RD'(rd); v.i.wb = 1'(wb); v.i.wbr = W_RD'(wbr);
    v.i.wbtag = W_TAG'(wbtag); v.i.res = W_OPR'(res);
    v.o.opr0 = W_OPR'(e0); v.o.opr1 = W_OPR'(e1); v.o.rsvd = 1'(ersv);
    v.o.ack = 1'(eack); v.o.tag = W_TAG'(etag);
    return v;
  endfunction

  task automatic drive(input int z, input in_t x);
    if (z == 0) begin
      bus0.r0_i = x.r0; bus0.r1_i = x.r1; bus0.r0_use_i = x.u0; bus0.r1_use_i = x.u1;
      bus0.rd_i = x.rd; bus0.w_reserve_i = x.wres; bus0.wb_i = x.wb;
      bus0.wb_r_i = x.wbr; bus0.wb_tag_i = x.wbtag; bus0.result_i = x.res;
    end else begin
      bus1.r0_i = x.r0; bus1.r1_i = x.r1; bus1.r0_use_i = x.u0; bus1.r1_use_i = x.u1;
      bus1.rd_i = x.rd; bus1.w_reserve_i = x.wres; bus1.wb_i = x.wb;
      bus1.wb_r_i = x.wbr; bus1.wb_tag_i = x.wbtag; bus1.result_i = x.res;
    end
  endtask

  function automatic out_t sample(input int z);
    out_t o;
    if (z == 0) begin
      o.opr0 = bus0.r_opr0_o; o.opr1 = bus0.r_opr1_o; o.rsvd = bus0.reserved_o;
      o.ack = bus0.rsv_ack_o; o.tag = bus0.rsv_tag_o;
    end else begin
      o.opr0 = bus1.r_opr0_o; o.opr1 = bus1.r_opr1_o; o.rsvd = bus1.reserved_o;
      o.ack = bus1.rsv_ack_o; o.tag = bus1.rsv_tag_o;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string name, input out_t a, input out_t e);
    chk({name, ".opr0"},     a.opr0, e.opr0);
    chk({name, ".opr1"},     a.opr1, e.opr1);
    chk({name, ".reserved"}, 32'(a.rsvd), 32'(e.rsvd));
    chk({name, ".ack"},      32'(a.ack), 32'(e.ack));
    chk({name, ".tag"},      32'(a.tag), 32'(e.tag));
  endtask

  task automatic m_reset();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < N_REG; r++) begin
        m_data[z][r] = '0; m_busy[z][r] = 1'b0; m_tag[z][r] = '0;
      end
      m_tcnt[z] = 0;
    end
  endtask

  function automatic bit m_hit(input int z, input int r, input in_t x);
    if (z == 1 && r == 0) return 1'b0;
    return x.wb && (int'(x.wbr) == r) && m_busy[z][r] && (x.wbtag == m_tag[z][r]);
  endfunction

  function automatic logic [W_OPR-1:0] m_read(input int z, input int r, input in_t x);
    if (z == 1 && r == 0) return '0;
    if (m_hit(z, r, x))   return x.res;
    return m_data[z][r];
  endfunction

  function automatic out_t m_eval(input int z, input in_t x);
    out_t o;
    bit p0, p1;
    p0 = x.u0 && m_busy[z][x.r0] && !m_hit(z, int'(x.r0), x);
    p1 = x.u1 && m_busy[z][x.r1] && !m_hit(z, int'(x.r1), x);
    o.opr0 = m_read(z, int'(x.r0), x);
    o.opr1 = m_read(z, int'(x.r1), x);
    o.rsvd = p0 || p1;
    o.ack  = x.wres && !(p0 || p1);
    o.tag  = W_TAG'(m_tcnt[z]);
    return o;
  endfunction

  task automatic m_step(input int z, input in_t x);
    out_t o;
    bit h;
    o = m_eval(z, x);
    h = m_hit(z, int'(x.wbr), x);
    if (h) begin
      m_data[z][x.wbr] = x.res;
      m_busy[z][x.wbr] = 1'b0;
    end
    if (o.ack && !(z == 1 && x.rd == 0)) begin
      m_busy[z][x.rd] = 1'b1;
      m_tag[z][x.rd]  = W_TAG'(m_tcnt[z]);
      m_tcnt[z]       = (m_tcnt[z] + 1) % (1 << W_TAG);
    end
  endtask

  function automatic in_t gen(input int z);
    in_t x;
    x.r0    = ($urandom_range(0, 3) == 0) ? '0 : W_RD'($urandom_range(0, N_REG - 1));
    x.r1    = W_RD'($urandom_range(0, N_REG - 1));
    x.u0    = 1'($urandom_range(0, 1));
    x.u1    = 1'($urandom_range(0, 1));
    x.rd    = ($urandom_range(0, 3) == 0) ? '0 : W_RD'($urandom_range(0, N_REG - 1));
    x.wres  = 1'($urandom_range(0, 1));
    x.wb    = ($urandom_range(0, 3) != 0);
    x.wbr   = W_RD'($urandom_range(0, N_REG - 1));
    x.wbtag = ($urandom_range(0, 3) != 0) ? m_tag[z][x.wbr] : W_TAG'($urandom_range(0, 7));
    x.res   = $urandom;
    return x;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    drive(0, idle_in());
    drive(1, idle_in());
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[$];
    in_t   x, xs[2];
    out_t  e, zero_o;
    m_reset();
    apply_reset();

    zero_o.opr0 = '0; zero_o.opr1 = '0; zero_o.rsvd = 1'b0; zero_o.ack = 1'b0; zero_o.tag = '0;
    #3;
    chk_out("reset0", sample(0), zero_o);
    chk_out("reset1", sample(1), zero_o);
    @(posedge clk); #1;

    //          r0 u0 r1 u1 wres rd wb wbr tag res      e0      e1   rsv ack tag
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0,0,          0,      0,    0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,3, 0,0,0,0,          0,      0,    0,1,0));
    tbl.push_back(mk(3,1,0,0, 0,0, 0,0,0,0,          0,      0,    1,0,1));
    tbl.push_back(mk(3,1,0,0, 0,0, 1,3,0,'h1234,     'h1234, 0,    0,0,1));
    tbl.push_back(mk(3,1,0,0, 0,0, 0,0,0,0,          'h1234, 0,    0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,5, 0,0,0,0,          0,      0,    0,1,1));
    tbl.push_back(mk(0,0,0,0, 1,5, 0,0,0,0,          0,      0,    0,1,2));
    tbl.push_back(mk(5,1,0,0, 0,0, 1,5,1,'hAA,       0,      0,    1,0,3));
    tbl.push_back(mk(5,1,0,0, 0,0, 1,5,2,'hBB,       'hBB,   0,    0,0,3));
    tbl.push_back(mk(5,1,0,0, 0,0, 0,0,0,0,          'hBB,   0,    0,0,3));
    tbl.push_back(mk(0,0,0,0, 1,1, 0,0,0,0,          0,      0,    0,1,3));
    tbl.push_back(mk(0,0,1,1, 1,7, 0,0,0,0,          0,      0,    1,0,4));
    tbl.push_back(mk(7,1,0,0, 0,0, 0,0,0,0,          0,      0,    0,0,4));
    tbl.push_back(mk(0,0,1,0, 1,7, 0,0,0,0,          0,      0,    0,1,4));
    tbl.push_back(mk(0,0,0,0, 1,2, 0,0,0,0,          0,      0,    0,1,5));
    tbl.push_back(mk(2,0,2,0, 1,2, 1,2,5,'h77,       'h77,   'h77, 0,1,6));
    tbl.push_back(mk(2,1,0,0, 0,0, 0,0,0,0,          'h77,   0,    1,0,7));
    tbl.push_back(mk(2,1,0,0, 0,0, 1,2,6,'h99,       'h99,   0,    0,0,7));
    tbl.push_back(mk(0,0,1,1, 0,0, 1,1,3,'h11,       0,      'h11, 0,0,7));
    tbl.push_back(mk(7,1,7,1, 0,0, 1,7,4,'h70,       'h70,   'h70, 0,0,7));
    tbl.push_back(mk(0,0,0,0, 1,9, 0,0,0,0,          0,      0,    0,1,7));
    tbl.push_back(mk(9,1,0,0, 1,10,0,0,0,0,          0,      0,    1,0,0));
    tbl.push_back(mk(9,0,0,0, 1,10,0,0,0,0,          0,      0,    0,1,0));
    tbl.push_back(mk(10,1,0,0,0,0, 0,0,0,0,          0,      0,    1,0,1));

    foreach (tbl[k]) begin
      drive(0, tbl[k].i);
      #3;
      chk_out($sformatf("tbl%0d", k), sample(0), tbl[k].o);
      @(posedge clk); #1;
    end

    apply_reset();
    for (int n = 0; n < 400; n++) begin
      for (int z = 0; z < 2; z++) begin
        xs[z] = gen(z);
        drive(z, xs[z]);
      end
      #3;
      for (int z = 0; z < 2; z++) chk_out($sformatf("rnd%0d_u%0d", n, z), sample(z), m_eval(z, xs[z]));
      @(posedge clk); #1;
      for (int z = 0; z < 2; z++) m_step(z, xs[z]);
    end

    // Zero register: writes and reservations to r0 have no effect.
    apply_reset();
    x = idle_in();
    x.r0 = 0; x.u0 = 1; x.r1 = 0; x.u1 = 1; x.wres = 1; x.rd = 0;
    x.wb = 1; x.wbr = 0; x.wbtag = 0; x.res = 'hFF;
    drive(1, x);
    #3;
    e = zero_o; e.ack = 1'b1;
    chk_out("zr_wr_rsv", sample(1), e);
    @(posedge clk); #1;
    x = idle_in(); x.u0 = 1; x.u1 = 1;
    drive(1, x);
    #3;
    chk_out("zr_after", sample(1), zero_o);
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      x = idle_in(); x.wres = 1; x.rd = W_RD'(k + 1);
      drive(1, x);
      #3;
      chk($sformatf("wrap%0d.tag", k), 32'(bus1.rsv_tag_o), 32'(k % 8));
      chk($sformatf("wrap%0d.ack", k), 32'(bus1.rsv_ack_o), 32'd1);
      @(posedge clk); #1;
    end
    drive(1, idle_in());

    // Asynchronous reset with reservations outstanding.
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      x = idle_in(); x.wres = 1; x.rd = W_RD'(k);
      drive(0, x);
      @(posedge clk); #1;
    end
    x = idle_in(); x.r0 = 4; x.u0 = 1; x.wb = 1; x.wbr = 4; x.wbtag = 3; x.res = 'h44;
    drive(0, x);
    #3;
    chk("rst_pre_byp", bus0.r_opr0_o, 32'h44);
    @(posedge clk); #1;
    x = idle_in(); x.wres = 1; x.rd = 4;
    drive(0, x);
    @(posedge clk); #1;
    x = idle_in(); x.r0 = 4; x.u0 = 1; x.r1 = 1; x.u1 = 1;
    drive(0, x);
    #3;
    chk("rst_pre.reserved", 32'(bus0.reserved_o), 32'd1);
    chk("rst_pre.opr0", bus0.r_opr0_o, 32'h44);
    chk("rst_pre.tag", 32'(bus0.rsv_tag_o), 32'd5);
    reset = 1'b0;
    #1;
    chk("rst_async.reserved", 32'(bus0.reserved_o), 32'd0);
    chk("rst_async.opr0", bus0.r_opr0_o, 32'd0);
    chk("rst_async.tag", 32'(bus0.rsv_tag_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    x = idle_in(); x.r0 = 1; x.u0 = 1; x.r1 = 4; x.u1 = 1;
    x.wb = 1; x.wbr = 1; x.wbtag = 0; x.res = 'h55;
    drive(0, x);
    #3;
    chk("stale_wb.opr0", bus0.r_opr0_o, 32'd0);
    chk("stale_wb.reserved", 32'(bus0.reserved_o), 32'd0);
    @(posedge clk); #1;
    x = idle_in(); x.r0 = 1; x.u0 = 1;
    drive(0, x);
    #3;
    chk("stale_wb_after.opr0", bus0.r_opr0_o, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
